clock_divider_mc: RTL and testbench

Multi-channel, runtime-programmable clock divider and tick generator for the egg-timer datapath. Each of NUM_CH independent channels divides `clk_in` into a 50 %-duty square wave and an optional one-cycle tick pulse. Divide values can be reloaded glitch-free while running, so the display-scan, seconds and buzzer time bases all come from one block.

---
 rtl/clock_divider_mc.sv | 76 +++++++
 tb/tb_clock_divider_mc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_mc.sv
// clock_divider_mc: NUM_CH runtime-reloadable 50% clock dividers with shadowed terminal counts.
// Define CLOCK_DIVIDER_TICK_EN to build the rising-edge tick pulses; otherwise tick is tied low.
module clock_divider_mc #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 5000
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] load,
    input  logic [CNT_W-1:0]  half_in,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
    logic [NUM_CH-1:0][CNT_W-1:0] count_q, count_d, term_q, term_d, shadow_q, shadow_d;
    logic [NUM_CH-1:0] clk_q, clk_d, pend_q, pend_d, hit;
    always_comb begin
        count_d  = count_q;
        term_d   = term_q;
        shadow_d = shadow_q;
        clk_d    = clk_q;
        pend_d   = pend_q;
        hit      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = count_q[i] == term_q[i];
            if (enable[i]) begin
                count_d[i] = hit[i] ? '0 : count_q[i] + CNT_W'(1);
                clk_d[i]   = clk_q[i] ^ hit[i];
                // term only moves on the wrap edge, so count can never overtake it
                if (hit[i] && pend_q[i]) begin
                    term_d[i] = shadow_q[i];
                    pend_d[i] = 1'b0;
                end
            end
            if (load[i]) begin
                shadow_d[i] = half_in;
                pend_d[i]   = 1'b1;
            end
        end
    end
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            term_q   <= {NUM_CH{HALF_RST}};
            shadow_q <= {NUM_CH{HALF_RST}};
            clk_q    <= '0;
            pend_q   <= '0;
        end else begin
            count_q  <= count_d;
            term_q   <= term_d;
            shadow_q <= shadow_d;
            clk_q    <= clk_d;
            pend_q   <= pend_d;
        end
    end
`ifdef CLOCK_DIVIDER_TICK_EN
    logic [NUM_CH-1:0] tick_q, tick_d;
    always_comb begin
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++)
            tick_d[i] = enable[i] & hit[i] & ~clk_q[i];
    end
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) tick_q <= '0;
        else          tick_q <= tick_d;
    end
    assign tick = tick_q;
`else
    assign tick = '0;
`endif
    assign clk_out = clk_q;
    assign pending = pend_q;
endmodule

// File: tb/tb_clock_divider_mc.sv
// tb_clock_divider_mc: countdown-style reference model checked every cycle, plus directed
// scenarios with hand-computed periods, latencies and pending behaviour.
module tb_clock_divider_mc;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int DH  = 5000;

    logic           clk_in = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] enable, load;
    logic [CW-1:0]  half_in;
    logic [NCH-1:0] clk_out, tick, pending;

    clock_divider_mc #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(DH)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .load(load),
        .half_in(half_in), .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each channel counts down the enabled cycles left in its current half-period.
    int             m_rem[NCH];
    int             m_term[NCH];
    int             m_shadow[NCH];
    logic [NCH-1:0] m_lvl, m_pend, m_tick;

    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_rem[i]    <= DH + 1;
                m_term[i]   <= DH;
                m_shadow[i] <= DH;
            end
            m_lvl  <= '0;
            m_pend <= '0;
            m_tick <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                int r, t, s;
                logic l, p, k;
                r = m_rem[i]; t = m_term[i]; s = m_shadow[i];
                l = m_lvl[i]; p = m_pend[i]; k = 1'b0;
                if (enable[i]) begin
                    r--;
                    if (r == 0) begin
                        k = !l;
                        l = !l;
                        if (p) begin
                            t = s;
                            p = 1'b0;
                        end
                        r = t + 1;
                    end
                end
                if (load[i]) begin
                    s = int'(half_in);
                    p = 1'b1;
                end
                m_rem[i]    <= r;
                m_term[i]   <= t;
                m_shadow[i] <= s;
                m_lvl[i]    <= l;
                m_pend[i]   <= p;
                m_tick[i]   <= k;
            end
        end
    end

    logic [NCH-1:0] exp_tick;
`ifdef CLOCK_DIVIDER_TICK_EN
    assign exp_tick = m_tick;
`else
    assign exp_tick = '0;
`endif

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        chk("model_clk_out", 32'(clk_out), 32'(m_lvl));
        chk("model_pending", 32'(pending), 32'(m_pend));
        chk("model_tick", 32'(tick), 32'(exp_tick));
    end

    // Rise-to-rise period of each DUT output, measured in clk_in cycles.
    int             last_rise[NCH];
    int             period[NCH];
    logic [NCH-1:0] prev_clk = '0;
    always @(negedge clk_in) begin
        for (int i = 0; i < NCH; i++) begin
            if (!reset_n) last_rise[i] <= -1;
            else if (!prev_clk[i] && clk_out[i]) begin
                if (last_rise[i] >= 0) period[i] <= cyc - last_rise[i];
                last_rise[i] <= cyc;
            end
        end
        prev_clk <= clk_out;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic wait_rise(input int ch, input int bound);
        logic p;
        int n;
        p = clk_out[ch];
        n = 0;
        while (n < bound) begin
            step(1);
            n++;
            if (!p && clk_out[ch]) return;
            p = clk_out[ch];
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_rise ch%0d: no rising edge within %0d cycles", ch, bound);
    endtask

    int rel;
    int n;
    initial begin
        reset_n = 1'b0;
        enable  = '0;
        load    = '0;
        half_in = '0;
        step(3);
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);

        reset_n = 1'b1;
        enable  = 4'hF;
        step(5000);
        chk("pre_first_rise", 32'(clk_out), 32'h0);
        step(1);
        chk("first_rise", 32'(clk_out), 32'hF);
`ifdef CLOCK_DIVIDER_TICK_EN
        chk("first_tick", 32'(tick), 32'hF);
`else
        chk("first_tick", 32'(tick), 32'h0);
`endif
        step(1);
        chk("tick_one_cycle", 32'(tick), 32'h0);

        step(2000);
        load    = 4'b0001;
        half_in = 16'd3;
        step(1);
        chk("pend0_set", 32'(pending), 32'h1);
        load    = 4'b0010;
        half_in = 16'd0;
        step(1);
        load = '0;
        chk("pend01_set", 32'(pending), 32'h3);
        n = 0;
        while (pending[1:0] != 2'b00 && n < 10100) begin
            step(1);
            n++;
        end
        chk("pend01_clear", 32'(pending), 32'h0);
        wait_rise(0, 20);
        wait_rise(0, 20);
        chk("ch0_period_8", 32'(period[0]), 32'd8);
        chk("ch1_period_2", 32'(period[1]), 32'd2);

        wait_rise(2, 10010);
        step(100);
        enable[2] = 1'b0;
        step(20);
        enable[2] = 1'b1;
        wait_rise(2, 10100);
        chk("ch2_stretched", 32'(period[2]), 32'd10022);
        chk("ch3_period", 32'(period[3]), 32'd10002);

        wait_rise(0, 20);
        load    = 4'b0001;
        half_in = 16'd7;
        step(1);
        load = '0;
        chk("coinc_pend_a", 32'(pending[0]), 32'h1);
        step(2);
        load    = 4'b0001;
        half_in = 16'd2;
        step(1);
        load = '0;
        chk("coinc_fall", 32'(clk_out[0]), 32'h0);
        chk("coinc_pend_b", 32'(pending[0]), 32'h1);
        wait_rise(0, 20);
        chk("coinc_period_12", 32'(period[0]), 32'd12);
        chk("coinc_pend_clr", 32'(pending[0]), 32'h0);
        wait_rise(0, 20);
        chk("coinc_period_6", 32'(period[0]), 32'd6);

        load    = 4'b1000;
        half_in = 16'd9;
        step(1);
        load = '0;
        chk("ch3_pend", 32'(pending), 32'h8);
        step(50);
        reset_n = 1'b0;
        #1;
        chk("async_clk_out", 32'(clk_out), 32'h0);
        chk("async_pending", 32'(pending), 32'h0);
        chk("async_tick", 32'(tick), 32'h0);
        step(3);
        reset_n = 1'b1;
        rel = cyc;
        wait_rise(3, 5010);
        chk("post_rst_first", 32'(last_rise[3] - rel), 32'd5001);
        wait_rise(3, 10010);
        chk("post_rst_period", 32'(period[3]), 32'd10002);
        chk("post_rst_pending", 32'(pending), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
